vfd_scan_engine: RTL and testbench

Parametrised successor to the fixed MN15439A Tri-SPI/GCP pair. It merges grid sequencing, blank/latch timing, N-lane grayscale serial output and GCP pulse generation into one reset-clean engine. The engine reads pixel words from the dual-port GRAM read port, which has 1-cycle latency. It drives the VFD pins directly, and the top level only wires pins and the GRAM.

---
 rtl/vfd_scan_engine.sv | 205 ++++++++++++++++++++
 tb/tb_vfd_scan_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfd_scan_engine.sv
// VFD scan engine: grid sequencing, blank/latch timing, N-lane grayscale shift
// out of GRAM and GCP pulse generation, all driven from one CLK domain.
module vfd_scan_engine #(
  parameter int LANES    = 3,
  parameter int GRIDS    = 52,
  parameter int ROWS     = 39,
  parameter int PIX_COLS = 156,
  parameter int ADDR_W   = 13,
  parameter int SCAN_DIV = 3846,
  parameter int LAT_W    = 3,
  parameter int BLK_W    = 120,
  parameter logic [(2**LANES-2)*10-1:0] GCP_T =
    {10'd72, 10'd144, 10'd192, 10'd216, 10'd240, 10'd256},
  parameter int GCP_W    = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  input  logic [LANES-1:0]  MEM_RDATA,
  output logic [LANES-1:0]  S,
  output logic              SCK,
  output logic              BLK,
  output logic              LAT,
  output logic              GCP,
  output logic [5:0]        GRID,
  output logic              FRAME_START,
  output logic              BUSY
);

  localparam int          PIXS  = ROWS * 6;
  localparam int          SLOTS = PIXS + GRIDS;
  localparam int          CYC   = 2 * SLOTS + 2;
  localparam int unsigned NGCP  = 2**LANES - 2;
  localparam int          CW    = $clog2(CYC);
  localparam int          TW    = $clog2(SCAN_DIV + 1);
  localparam int          BW    = $clog2(BLK_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]        state;
  logic [TW-1:0]     tcnt;
  logic [BW-1:0]     bcnt;
  logic [CW-1:0]     c;
  logic [2:0]        k;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] grp_off;
  logic [ADDR_W-1:0] addr_q;
  logic [5:0]        grid_q;
  logic [LANES-1:0]  s_q;
  logic              sck_q, blk_q, lat_q, gcp_q, fs_q;

  logic              tick, is_pix, last_cyc, pass, grid_hit;
  logic [CW-1:0]     slot, gbase;
  logic [2:0]        k_nxt;
  logic [ADDR_W-1:0] roff_nxt;
  logic [LANES-1:0]  slot_data;

  // AFBECD shift order within a 6-pixel group
  function automatic logic [2:0] ord_of(input logic [2:0] kk);
    logic [2:0] o;
    case (kk)
      3'd0:    o = 3'd0;
      3'd1:    o = 3'd5;
      3'd2:    o = 3'd1;
      3'd3:    o = 3'd4;
      3'd4:    o = 3'd2;
      default: o = 3'd3;
    endcase
    return o;
  endfunction

  function automatic logic gcp_at(input logic [CW-1:0] x);
    logic hit;
    int   t;
    hit = 1'b0;
    for (int unsigned i = 0; i < NGCP; i++) begin
      t = int'(GCP_T[i*10 +: 10]);
      if (int'(x) >= t && int'(x) < t + GCP_W) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    tick      = EN && (tcnt == TW'(SCAN_DIV - 1));
    slot      = {1'b0, c[CW-1:1]};
    is_pix    = c < CW'(2 * PIXS);
    last_cyc  = c == CW'(CYC - 1);
    k_nxt     = (k == 3'd5) ? 3'd0 : k + 3'd1;
    roff_nxt  = (k == 3'd5) ? row_off + ADDR_W'(PIX_COLS) : row_off;
    pass      = (ord_of(k) >= 3'd3) == grid_q[0];
    gbase     = CW'(PIXS) + CW'(grid_q);
    grid_hit  = (slot == gbase) ||
                ((slot == gbase + CW'(1)) && (grid_q != 6'(GRIDS - 1)));
    slot_data = '0;
    if (is_pix) begin
      if (pass) slot_data = MEM_RDATA;
    end else if (grid_hit) begin
      slot_data = '1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      tcnt    <= '0;
      bcnt    <= '0;
      c       <= '0;
      k       <= '0;
      row_off <= '0;
      grp_off <= '0;
      addr_q  <= '0;
      grid_q  <= '0;
      s_q     <= '0;
      sck_q   <= 1'b0;
      blk_q   <= 1'b0;
      lat_q   <= 1'b0;
      gcp_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (!EN || tick) tcnt <= '0;
      else             tcnt <= tcnt + TW'(1);

      if (!EN) begin
        state <= IDLE;
        s_q   <= '0;
        sck_q <= 1'b0;
        blk_q <= 1'b0;
        lat_q <= 1'b0;
        gcp_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tick) begin
              state   <= BLANK;
              blk_q   <= 1'b1;
              lat_q   <= (LAT_W > 0);
              bcnt    <= '0;
              // (GRID>>1)*6 as two shifted adds, latched once per scan
              grp_off <= ADDR_W'({grid_q[5:1], 2'b00}) + ADDR_W'({grid_q[5:1], 1'b0});
            end
          end
          BLANK: begin
            if (bcnt == BW'(BLK_W - 1)) begin
              state   <= SHIFT;
              blk_q   <= 1'b0;
              lat_q   <= 1'b0;
              c       <= '0;
              k       <= '0;
              row_off <= '0;
              addr_q  <= grp_off;
              gcp_q   <= gcp_at('0);
            end else begin
              bcnt  <= bcnt + BW'(1);
              lat_q <= (int'(bcnt) + 1 < LAT_W);
            end
          end
          SHIFT: begin
            if (last_cyc) begin
              state  <= IDLE;
              s_q    <= '0;
              sck_q  <= 1'b0;
              gcp_q  <= 1'b0;
              fs_q   <= (grid_q == 6'(GRIDS - 1));
              grid_q <= (grid_q == 6'(GRIDS - 1)) ? '0 : grid_q + 6'd1;
            end else begin
              c     <= c + CW'(1);
              gcp_q <= gcp_at(c + CW'(1));
              // P1 captures the slot word; the following cycle raises SCK
              if (c[0]) begin
                s_q   <= slot_data;
                sck_q <= 1'b0;
              end else if (c != '0) begin
                sck_q <= 1'b1;
              end
              if (c[0] && is_pix) begin
                k       <= k_nxt;
                row_off <= roff_nxt;
                if (c < CW'(2 * PIXS - 1))
                  addr_q <= roff_nxt + grp_off + ADDR_W'(ord_of(k_nxt));
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign MEM_ADDR    = addr_q;
  assign MEM_RE      = (state == SHIFT) && !c[0] && is_pix;
  assign S           = s_q;
  assign SCK         = sck_q;
  assign BLK         = blk_q;
  assign LAT         = lat_q;
  assign GCP         = gcp_q;
  assign GRID        = grid_q;
  assign FRAME_START = fs_q;
  assign BUSY        = state != IDLE;

endmodule

// File: tb/tb_vfd_scan_engine.sv
// Directed bench: default-timing instance for blank/latch/GCP/reset timing,
// fast-tick instance for full scan content, grid stepping and EN drop.
module tb_vfd_scan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int prev_rise = -1;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic        rst_n, en;
  logic [12:0] mem_addr;
  logic        mem_re;
  logic [2:0]  mem_rdata = '0;
  logic [2:0]  s;
  logic        sck, blk, lat, gcp, frame_start, busy;
  logic [5:0]  grid;

  // fast-tick instance
  logic        rst_n_f, en_f;
  logic [12:0] mem_addr_f;
  logic        mem_re_f;
  logic [2:0]  mem_rdata_f = '0;
  logic [2:0]  s_f;
  logic        sck_f, blk_f, lat_f, gcp_f, frame_start_f, busy_f;
  logic [5:0]  grid_f;

  vfd_scan_engine u_dut (
    .CLK(clk), .RST_N(rst_n), .EN(en),
    .MEM_ADDR(mem_addr), .MEM_RE(mem_re), .MEM_RDATA(mem_rdata),
    .S(s), .SCK(sck), .BLK(blk), .LAT(lat), .GCP(gcp),
    .GRID(grid), .FRAME_START(frame_start), .BUSY(busy)
  );

  vfd_scan_engine #(.SCAN_DIV(400)) u_dut_f (
    .CLK(clk), .RST_N(rst_n_f), .EN(en_f),
    .MEM_ADDR(mem_addr_f), .MEM_RE(mem_re_f), .MEM_RDATA(mem_rdata_f),
    .S(s_f), .SCK(sck_f), .BLK(blk_f), .LAT(lat_f), .GCP(gcp_f),
    .GRID(grid_f), .FRAME_START(frame_start_f), .BUSY(busy_f)
  );

  function automatic logic [2:0] gram(input logic [12:0] a);
    return a[2:0] + 3'd2;
  endfunction

  always @(posedge clk) if (mem_re)   mem_rdata   <= gram(mem_addr);
  always @(posedge clk) if (mem_re_f) mem_rdata_f <= gram(mem_addr_f);

  function automatic int ord_of(input int kk);
    int tbl[6] = '{0, 5, 1, 4, 2, 3};
    return tbl[kk];
  endfunction

  function automatic int exp_addr(input int g, input int sl);
    return (sl / 6) * 156 + (g / 2) * 6 + ord_of(sl % 6);
  endfunction

  function automatic logic [2:0] exp_slot(input int g, input int sl);
    logic [12:0] a;
    int o, j;
    if (sl < 234) begin
      o = ord_of(sl % 6);
      a = 13'(exp_addr(g, sl));
      if (((g % 2) == 0) ? (o < 3) : (o >= 3)) return gram(a);
      return 3'b000;
    end
    j = sl - 234;
    if (j == g || (j == g + 1 && g + 1 < 52)) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic gcp_exp(input int c);
    return (c >= 72  && c <= 74)  || (c >= 144 && c <= 146) ||
           (c >= 192 && c <= 194) || (c >= 216 && c <= 218) ||
           (c >= 240 && c <= 242) || (c >= 256 && c <= 258);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rst_n_f = 1'b0; en = 1'b0; en_f = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s, sck, blk, lat, gcp, mem_re, frame_start, busy} !== 10'd0) begin
      errors++; $display("FAIL reset_pins: got %b expected 0", {s, sck, blk, lat, gcp, mem_re, frame_start, busy});
    end
    checks++;
    if (grid !== 6'd0 || mem_addr !== 13'd0) begin
      errors++; $display("FAIL reset_grid_addr: got grid=%0d addr=%0d expected 0/0", grid, mem_addr);
    end
    checks++;
    if ({s_f, sck_f, blk_f, lat_f, gcp_f, mem_re_f, frame_start_f, busy_f} !== 10'd0) begin
      errors++; $display("FAIL reset_pins_f: got %b expected 0", {s_f, sck_f, blk_f, lat_f, gcp_f, mem_re_f, frame_start_f, busy_f});
    end
    checks++;
    if (grid_f !== 6'd0 || mem_addr_f !== 13'd0) begin
      errors++; $display("FAIL reset_grid_addr_f: got grid=%0d addr=%0d expected 0/0", grid_f, mem_addr_f);
    end
    rst_n = 1'b1; rst_n_f = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_scan();
    int first_blk = -1, sh = -1, first_sck = -1;
    int blk_len = 0, lat_len = 0, rises = 0, gcp_bad = 0;
    logic seen = 0, done = 0, prev_sck = 0, prev_blk = 0, eg;
    @(posedge clk); #1 en = 1'b1;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      if (blk && !prev_blk && first_blk < 0) first_blk = n;
      if (!blk && prev_blk && sh < 0) sh = n;
      blk_len += int'(blk);
      lat_len += int'(lat);
      if (sck && !prev_sck) begin
        rises++;
        if (first_sck < 0) first_sck = n;
      end
      eg = (sh >= 0) && gcp_exp(n - sh);
      if (gcp !== eg) gcp_bad++;
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
      prev_sck = sck; prev_blk = blk;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL first_scan_timeout: got busy=%b expected scan to end", busy); end
    checks++;
    if (first_blk != 3846) begin errors++; $display("FAIL blk_rise: got cycle %0d expected 3846", first_blk); end
    checks++;
    if (lat_len != 3) begin errors++; $display("FAIL lat_len: got %0d expected 3", lat_len); end
    checks++;
    if (blk_len != 120) begin errors++; $display("FAIL blk_len: got %0d expected 120", blk_len); end
    checks++;
    if (sh != 3966) begin errors++; $display("FAIL blk_fall: got cycle %0d expected 3966", sh); end
    checks++;
    if (first_sck != 3969) begin errors++; $display("FAIL first_sck: got cycle %0d expected 3969", first_sck); end
    checks++;
    if (rises != 286) begin errors++; $display("FAIL sck_rises: got %0d expected 286", rises); end
    checks++;
    if (gcp_bad != 0) begin errors++; $display("FAIL gcp_pattern: got %0d bad cycles expected 0", gcp_bad); end
    checks++;
    if (grid !== 6'd1) begin errors++; $display("FAIL grid_after_first: got %0d expected 1", grid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4000 && !blk; i++) @(negedge clk);
    checks++;
    if (blk !== 1'b1 || lat !== 1'b1) begin
      errors++; $display("FAIL async_pre: got blk=%b lat=%b expected 1/1", blk, lat);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (blk !== 1'b0 || lat !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got blk=%b lat=%b busy=%b expected 0/0/0", blk, lat, busy);
    end
    checks++;
    if (grid !== 6'd0) begin errors++; $display("FAIL async_grid: got %0d expected 0", grid); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan(input int g);
    int bad_re = 0, bad_addr = 0, bad_s = 0, bad_gcp = 0, rises = 0, first_bad = -1;
    int blk_len = 0, lat_len = 0, rise_cyc;
    logic prev_sck = 0, exp_re;
    logic [2:0] exp_s, bad_got, bad_exp;
    logic exp_sck;
    for (int i = 0; i < 1000 && !blk_f; i++) @(negedge clk);
    checks++;
    if (!blk_f) begin
      errors++; $display("FAIL scan_start g=%0d: got blk=%b expected 1 within bound", g, blk_f);
      return;
    end
    rise_cyc = cyc;
    if (prev_rise >= 0) begin
      checks++;
      if (rise_cyc - prev_rise != 800) begin
        errors++; $display("FAIL tick_drop g=%0d: got period %0d expected 800", g, rise_cyc - prev_rise);
      end
    end
    prev_rise = rise_cyc;
    checks++;
    if (grid_f !== 6'(g)) begin errors++; $display("FAIL scan_grid: got %0d expected %0d", grid_f, g); end
    for (int i = 0; i < 300 && blk_f; i++) begin
      blk_len++;
      lat_len += int'(lat_f);
      @(negedge clk);
    end
    checks++;
    if (blk_len != 120 || lat_len != 3) begin
      errors++; $display("FAIL blank_f g=%0d: got blk=%0d lat=%0d expected 120/3", g, blk_len, lat_len);
    end
    for (int c = 0; c < 574; c++) begin
      exp_re = (c % 2 == 0) && (c / 2 < 234);
      if (mem_re_f !== exp_re) bad_re++;
      else if (exp_re && mem_addr_f !== 13'(exp_addr(g, c / 2))) bad_addr++;
      exp_s   = (c >= 2) ? exp_slot(g, (c - 2) / 2) : 3'b000;
      exp_sck = (c >= 2) && (c % 2 == 1);
      if (s_f !== exp_s || sck_f !== exp_sck || busy_f !== 1'b1) begin
        if (first_bad < 0) begin first_bad = c; bad_got = s_f; bad_exp = exp_s; end
        bad_s++;
      end
      if (gcp_f !== gcp_exp(c)) bad_gcp++;
      if (sck_f && !prev_sck) rises++;
      prev_sck = sck_f;
      if (g == 3 && c == 26) begin
        checks++;
        if (mem_addr_f !== 13'd323 || mem_re_f !== 1'b1) begin
          errors++; $display("FAIL addr_g3: got addr=%0d re=%b expected 323/1", mem_addr_f, mem_re_f);
        end
      end
      if (g == 3 && c == 28) begin
        checks++;
        if (s_f !== 3'b101) begin errors++; $display("FAIL data_g3: got %b expected 101", s_f); end
      end
      if (g == 2 && c == 28) begin
        checks++;
        if (s_f !== 3'b000) begin errors++; $display("FAIL mask_g2: got %b expected 000", s_f); end
      end
      @(negedge clk);
    end
    checks++;
    if (bad_re != 0 || bad_addr != 0) begin
      errors++; $display("FAIL mem_port g=%0d: got %0d re / %0d addr bad cycles expected 0", g, bad_re, bad_addr);
    end
    checks++;
    if (bad_s != 0) begin
      errors++; $display("FAIL serial g=%0d: got %0d bad cycles (first c=%0d s=%b) expected 0 (s=%b)", g, bad_s, first_bad, bad_got, bad_exp);
    end
    checks++;
    if (bad_gcp != 0) begin errors++; $display("FAIL gcp_f g=%0d: got %0d bad cycles expected 0", g, bad_gcp); end
    checks++;
    if (rises != 286) begin errors++; $display("FAIL rises_f g=%0d: got %0d expected 286", g, rises); end
    checks++;
    if (busy_f !== 1'b0 || grid_f !== 6'((g + 1) % 52) || frame_start_f !== (g == 51) || s_f !== 3'b000 || sck_f !== 1'b0) begin
      errors++; $display("FAIL scan_end g=%0d: got busy=%b grid=%0d fs=%b s=%b sck=%b expected 0/%0d/%b/0/0",
                         g, busy_f, grid_f, frame_start_f, s_f, sck_f, (g + 1) % 52, g == 51);
    end
    if (g == 51) begin
      @(negedge clk);
      checks++;
      if (frame_start_f !== 1'b0) begin errors++; $display("FAIL fs_width: got %b expected 0", frame_start_f); end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 en_f = 1'b1;
    for (int g = 0; g < 52; g++) test_scan(g);
    test_scan(0);
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < 1000 && !blk_f; i++) @(negedge clk);
    for (int i = 0; i < 300 && blk_f; i++) @(negedge clk);
    for (int c = 0; c < 200; c++) @(negedge clk);
    checks++;
    if (busy_f !== 1'b1) begin errors++; $display("FAIL en_drop_pre: got busy=%b expected 1", busy_f); end
    en_f = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_f, sck_f, blk_f, lat_f, gcp_f, mem_re_f, busy_f} !== 9'd0) begin
      errors++; $display("FAIL en_drop_pins: got %b expected 0", {s_f, sck_f, blk_f, lat_f, gcp_f, mem_re_f, busy_f});
    end
    checks++;
    if (grid_f !== 6'd1) begin errors++; $display("FAIL en_drop_grid: got %0d expected 1", grid_f); end
    repeat (5) @(negedge clk);
    prev_rise = -1;
    @(posedge clk); #1 en_f = 1'b1;
    test_scan(1);
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_async_reset();
    test_back_to_back();
    test_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
